// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO and its drain stage.
//   FIFO_DATA_WIDTH   default width of one FIFO entry
//   FIFO_ENTRIES      default FIFO depth
//   fifo_pack_state_e read-packer FSM states (FILL collects entries, OUT holds a word)
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_ENTRIES    = 16;

   typedef enum logic {
      FILL,
      OUT
   } fifo_pack_state_e;

endpackage

// File: rtl/fifo_flush_timer.sv
// fifo_flush_timer: idle-cycle counter for the read packer's auto-flush.
// Only instantiated when FIFO_RD_PACKER_FLUSH_EN is defined.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   clr_i  restart the count (a capture happened)
//   en_i   count this cycle (idle FILL cycle with a partial word)
//   tc_o   terminal count: TIMEOUT-th consecutive enabled cycle
module fifo_flush_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any non-enabled cycle breaks the run, so only consecutive idle cycles count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DATA_WIDTH entries from a 1-cycle-latency FIFO read
// port and packs PACK_RATIO of them (first pop in lane 0) into one word on a
// valid/ready master interface.
// Optional feature macro: FIFO_RD_PACKER_FLUSH_EN adds the flush port and an
// idle timer that push out partial words (m_keep marks filled lanes).
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       synchronous active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop request, data returns next cycle
//   fifo_rd_data  FIFO read data
//   m_data        packed word, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_keep        per-lane valid mask
//   m_valid       packed word valid (registered)
//   m_ready       consumer accepts word
//   flush         force out a partial word (FIFO_RD_PACKER_FLUSH_EN only)
//   busy          lanes filled, read in flight or word pending
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int PACK_RATIO = 4
`ifdef FIFO_RD_PACKER_FLUSH_EN
   ,
   parameter int FLUSH_TIMEOUT = 16
`endif
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
   output logic [PACK_RATIO-1:0]            m_keep,
   output logic                             m_valid,
   input  logic                             m_ready,
`ifdef FIFO_RD_PACKER_FLUSH_EN
   input  logic                             flush,
`endif
   output logic                             busy
);

   localparam int LW = $clog2(PACK_RATIO + 1);

   fifo_pack_state_e                 state_q, state_d;
   logic [LW-1:0]                    lanes_q, lanes_d;
   logic                             inflight_q;
   logic [DATA_WIDTH*PACK_RATIO-1:0] data_q, data_d;
   logic [PACK_RATIO-1:0]            keep_q, keep_d;
   logic                             flush_req;

`ifdef FIFO_RD_PACKER_FLUSH_EN
   logic timer_tc;

   fifo_flush_timer #(
      .TIMEOUT (FLUSH_TIMEOUT)
   ) u_flush_timer (
      .clk_i (sys_clk),
      .rst_i (sys_rst),
      .clr_i (inflight_q),
      .en_i  ((state_q == FILL) && (lanes_q != '0) && !inflight_q),
      .tc_o  (timer_tc)
   );

   assign flush_req = (state_q == FILL) && (lanes_q != '0) && (flush || timer_tc);
`else
   assign flush_req = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lanes_d    = lanes_q;
      data_d     = data_q;
      keep_d     = keep_q;
      fifo_rd_en = 1'b0;
      case (state_q)
         FILL: begin
            // A pending flush stops new pops so no entry is left in flight
            // when the word leaves; an entry already in flight is still
            // captured and closes the word on the same edge.
            fifo_rd_en = !fifo_empty && !sys_rst && !flush_req &&
                         ((int'(lanes_q) + int'(inflight_q)) < PACK_RATIO);
            if (inflight_q) begin
               for (int unsigned k = 0; k < PACK_RATIO; k++) begin
                  if (LW'(k) == lanes_q) begin
                     data_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                     keep_d[k]                          = 1'b1;
                  end
               end
               lanes_d = lanes_q + LW'(1);
               if ((lanes_d == LW'(PACK_RATIO)) || flush_req) begin
                  state_d = OUT;
               end
            end else if (flush_req) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               state_d = FILL;
               lanes_d = '0;
               data_d  = '0;
               keep_d  = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= FILL;
         lanes_q    <= '0;
         inflight_q <= 1'b0;
         data_q     <= '0;
         keep_q     <= '0;
      end else begin
         state_q    <= state_d;
         lanes_q    <= lanes_d;
         inflight_q <= fifo_rd_en;
         data_q     <= data_d;
         keep_q     <= keep_d;
      end
   end

   assign m_valid = (state_q == OUT);
   assign m_data  = data_q;
   assign m_keep  = keep_q;
   assign busy    = (lanes_q != '0) || inflight_q || (state_q == OUT);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed self-checking bench for fifo_rd_packer with a
// small 1-cycle-latency FIFO model. Flush cases run when
// FIFO_RD_PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data = 8'hEE;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy;
`ifdef FIFO_RD_PACKER_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   always #5 sys_clk = ~sys_clk;

   fifo_rd_packer #(
      .DATA_WIDTH (8),
      .PACK_RATIO (4)
`ifdef FIFO_RD_PACKER_FLUSH_EN
      ,
      .FLUSH_TIMEOUT (16)
`endif
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_data       (m_data),
      .m_keep       (m_keep),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
`ifdef FIFO_RD_PACKER_FLUSH_EN
      .flush        (flush),
`endif
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // FIFO model: read data appears the cycle after fifo_rd_en; junk otherwise.
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge sys_clk) begin
      if (fifo_rd_en) begin
         check_eq("pop_nonempty", {63'd0, fifo_empty}, 64'd0);
         fifo_rd_data <= mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
      end else begin
         fifo_rd_data <= 8'hEE;
      end
   end

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[7:0]] = d;
      wr_ptr           = wr_ptr + 1;
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic reset_dut();
      sys_rst = 1'b1;
      step();
      step();
   endtask

   task automatic release_rst();
      step();
      sys_rst = 1'b0;
   endtask

   // Returns at the falling edge of the first cycle with m_valid high.
   task automatic wait_word(input string tag, input int budget);
      int n = 0;
      forever begin
         @(negedge sys_clk);
         if (m_valid || n >= budget) break;
         n++;
         step();
      end
      check_eq(tag, {63'd0, m_valid}, 64'd1);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         @(negedge sys_clk);
         check_eq(tag, {63'd0, m_valid}, 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held three cycles
      sys_rst = 1'b1;
      m_ready = 1'b1;
      step(); step(); step();
      @(negedge sys_clk);
      check_eq("rst_m_valid", {63'd0, m_valid}, 64'd0);
      check_eq("rst_m_keep", {60'd0, m_keep}, 64'd0);
      check_eq("rst_m_data", {32'd0, m_data}, 64'd0);
      check_eq("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);

      // Basic pack: cycle-accurate read issue and output timing
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      release_rst();
      for (int n = 0; n < 8; n++) begin
         @(negedge sys_clk);
         check_eq($sformatf("basic_rd_en_c%0d", n), {63'd0, fifo_rd_en}, {63'd0, (n <= 3)});
         check_eq($sformatf("basic_valid_c%0d", n), {63'd0, m_valid}, {63'd0, (n == 5)});
         check_eq($sformatf("basic_busy_c%0d", n), {63'd0, busy}, {63'd0, (n >= 1 && n <= 5)});
         if (n == 5) begin
            check_eq("basic_data", {32'd0, m_data}, 64'h44332211);
            check_eq("basic_keep", {60'd0, m_keep}, 64'hF);
         end
         if (n == 6) begin
            check_eq("basic_data_clr", {32'd0, m_data}, 64'd0);
            check_eq("basic_keep_clr", {60'd0, m_keep}, 64'd0);
         end
         step();
      end

      // Backpressure: word held stable, no pops while m_ready is low
      reset_dut();
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      release_rst();
      wait_word("bp_first_timeout", 20);
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_valid", {63'd0, m_valid}, 64'd1);
         check_eq("bp_data", {32'd0, m_data}, 64'h04030201);
         check_eq("bp_keep", {60'd0, m_keep}, 64'hF);
         check_eq("bp_rd_en", {63'd0, fifo_rd_en}, 64'd0);
         step();
         @(negedge sys_clk);
      end
      step();
      m_ready = 1'b1;
      @(negedge sys_clk);
      check_eq("bp_hold_data", {32'd0, m_data}, 64'h04030201);
      step();
      wait_word("bp_second_timeout", 20);
      check_eq("bp_second_data", {32'd0, m_data}, 64'h08070605);
      check_eq("bp_second_keep", {60'd0, m_keep}, 64'hF);
      expect_quiet("bp_no_extra", 4);
      step();

      // Empty gap: partial word retained while the FIFO is empty
      reset_dut();
      push(8'h0A); push(8'h0B);
      release_rst();
      step(); step(); step();
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         check_eq("gap_valid", {63'd0, m_valid}, 64'd0);
         check_eq("gap_rd_en", {63'd0, fifo_rd_en}, 64'd0);
         check_eq("gap_busy", {63'd0, busy}, 64'd1);
         step();
      end
      push(8'h0C); push(8'h0D);
      wait_word("gap_timeout", 20);
      check_eq("gap_data", {32'd0, m_data}, 64'h0D0C0B0A);
      check_eq("gap_keep", {60'd0, m_keep}, 64'hF);
      expect_quiet("gap_no_extra", 4);
      step();

`ifdef FIFO_RD_PACKER_FLUSH_EN
      // Flush while an entry is in flight: that entry is included
      reset_dut();
      push(8'hAA); push(8'hBB); push(8'hCC);
      release_rst();
      step(); step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_word("flush_timeout", 20);
      check_eq("flush_data", {32'd0, m_data}, 64'h00CCBBAA);
      check_eq("flush_keep", {60'd0, m_keep}, 64'h7);
      expect_quiet("flush_no_extra", 3);
      // Flush with no lanes filled is ignored
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge sys_clk);
      check_eq("flush_empty_ignored", {63'd0, m_valid}, 64'd0);
      expect_quiet("flush_empty_quiet", 3);
      step();

      // Idle timeout: single entry flushed FLUSH_TIMEOUT+1 cycles after capture
      reset_dut();
      push(8'h5A);
      release_rst();
      for (int n = 0; n <= 18; n++) begin
         @(negedge sys_clk);
         check_eq($sformatf("tmo_valid_c%0d", n), {63'd0, m_valid}, {63'd0, (n == 18)});
         if (n < 18) step();
      end
      check_eq("tmo_data", {32'd0, m_data}, 64'h0000005A);
      check_eq("tmo_keep", {60'd0, m_keep}, 64'h1);
      step();
`endif

      // Reset mid-fill: stale partial word is dropped
      reset_dut();
      push(8'h01); push(8'h02);
      release_rst();
      step(); step(); step();
      sys_rst = 1'b1;
      push(8'h10); push(8'h11); push(8'h12); push(8'h13);
      step();
      sys_rst = 1'b0;
      wait_word("rstmid_timeout", 20);
      check_eq("rstmid_data", {32'd0, m_data}, 64'h13121110);
      check_eq("rstmid_keep", {60'd0, m_keep}, 64'hF);
      expect_quiet("rstmid_no_extra", 8);
      check_eq("rstmid_fifo_drained", {63'd0, fifo_empty}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
